// File: rtl/seven_seg_pkg.sv
// Shared glyphs, pin idle levels and the digit index type for the
// seven-segment scanner.
package seven_seg_pkg;

  typedef logic [2:0] digit_idx_t;

  localparam logic [7:0] ANODE_OFF   = 8'hFF;
  localparam logic [7:0] CATHODE_OFF = 8'hFF;

  // active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/seven_seg_scanner_hex.sv
// Nibble to active-low seven-segment glyph decoder.
// Purely combinational; used once per scanner for the selected digit.
import seven_seg_pkg::*;

module hex_to_seg7 (
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_0;
    unique case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// 8-digit multiplexed seven-segment driver with tear-free frame commit.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
import seven_seg_pkg::*;

module seven_seg_scanner #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_i,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic [7:0]  dp_i,
  input  logic [7:0]  digit_en,
  output logic [7:0]  anode,
  output logic [7:0]  cathode,
  output logic        frame_start
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] CNT_MAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] cnt;
  digit_idx_t    idx;
  logic [31:0]   disp_reg;
  logic [31:0]   pend_reg;
  logic          pend_full;
  logic          tick;
  logic          accept;
  logic          commit;
  logic [3:0]    nib;
  logic [6:0]    seg;
  logic          blank;
  logic          show;

  assign tick        = (cnt == CNT_MAX);
  assign frame_start = tick && (idx == 3'd7);
  assign data_ready  = !pend_full;
  assign accept      = data_valid && data_ready;
  assign commit      = frame_start && pend_full;
  assign nib         = disp_reg[{idx, 2'b00} +: 4];

  hex_to_seg7 u_hex (
    .nib (nib),
    .seg (seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // hi_zero[k]: nibble k and every nibble above it are zero
  logic [7:0] hi_zero;

  always_comb begin
    hi_zero = '0;
    for (int k = 0; k < 8; k++)
      hi_zero[k] = ((disp_reg >> (4 * k)) == 32'h0);
  end

  assign blank = (idx != 3'd0) && hi_zero[idx];
`else
  assign blank = 1'b0;
`endif

  assign show = digit_en[idx] && !blank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + PW'(1);
      if (tick)
        idx <= idx + 3'd1;
    end
  end

  // accept and commit are exclusive: commit needs pend_full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_reg  <= '0;
      pend_full <= 1'b0;
      disp_reg  <= '0;
    end else if (accept) begin
      pend_reg  <= data_i;
      pend_full <= 1'b1;
    end else if (commit) begin
      disp_reg  <= pend_reg;
      pend_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode   <= ANODE_OFF;
      cathode <= CATHODE_OFF;
    end else if (show) begin
      anode   <= ~(8'b1 << idx);
      cathode <= {~dp_i[idx], seg};
    end else begin
      anode   <= ANODE_OFF;
      cathode <= CATHODE_OFF;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner with REFRESH_DIV=4.
// Build with LEADING_ZERO_BLANK_EN to check the blanking variant.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_i;
  logic        data_valid;
  logic        data_ready;
  logic [7:0]  dp_i;
  logic [7:0]  digit_en;
  logic [7:0]  anode;
  logic [7:0]  cathode;
  logic        frame_start;

  seven_seg_scanner #(.REFRESH_DIV(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_i      (data_i),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .dp_i        (dp_i),
    .digit_en    (digit_en),
    .anode       (anode),
    .cathode     (cathode),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] an;
    logic [7:0] ca;
    int         len;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic push(input logic [7:0] an, input logic [7:0] ca,
                      input int len);
    exp_t e;
    e.an = an;
    e.ca = ca;
    e.len = len;
    sb.push_back(e);
  endtask

  // monitor: every change of the pins is one presented digit
  logic [7:0] prev_an, prev_ca;
  int run = 0;
  int exp_len = 0;
  bit have = 1'b0;

  always @(negedge clk) begin
    if (!mon_on) begin
      have = 1'b0;
      prev_an = anode;
      prev_ca = cathode;
    end else if (anode != prev_an || cathode != prev_ca) begin
      if (have && exp_len != 0)
        chk("hold_len", run, exp_len);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_change actual=%h/%h required=none",
                 anode, cathode);
        have = 1'b0;
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("anode", anode, e.an);
        chk("cathode", cathode, e.ca);
        exp_len = e.len;
        have = 1'b1;
      end
      prev_an = anode;
      prev_ca = cathode;
      run = 1;
    end else begin
      run++;
    end
  end

  task automatic send(input logic [31:0] d);
    @(negedge clk);
    data_i = d;
    data_valid = 1'b1;
    chk("ready_before_send", data_ready, 1'b1);
    @(negedge clk);
    data_valid = 1'b0;
    chk("ready_after_send", data_ready, 1'b0);
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 100);
    chk("frame_start_seen", frame_start, 1'b1);
  endtask

  task automatic start_mon();
    #1 mon_on = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    mon_on = 1'b0;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    data_i = '0;
    data_valid = 1'b0;
    dp_i = 8'h00;
    digit_en = 8'hFF;

    repeat (3) @(negedge clk);
    chk("rst_anode", anode, 8'hFF);
    chk("rst_cathode", cathode, 8'hFF);
    chk("rst_frame_start", frame_start, 1'b0);
    chk("rst_ready", data_ready, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("first_anode", anode, 8'hFE);
    chk("first_cathode", cathode, 8'hC0);

    // full frame of 76543210
    send(32'h76543210);
    wait_frame();
    push(8'hFE, 8'hC0, 4);
    push(8'hFD, 8'hF9, 4);
    push(8'hFB, 8'hA4, 4);
    push(8'hF7, 8'hB0, 4);
    push(8'hEF, 8'h99, 4);
    push(8'hDF, 8'h92, 4);
    push(8'hBF, 8'h82, 4);
    push(8'h7F, 8'hF8, 0);
    start_mon();
    @(negedge clk);
    chk("ready_after_commit", data_ready, 1'b1);
    drain();

    // mid-frame accept, second offer ignored while pending
    wait_frame();
    repeat (10) @(negedge clk);
    send(32'hDEADBEEF);
    data_i = 32'h11111111;
    data_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("ready_while_pending", data_ready, 1'b0);
    data_valid = 1'b0;
    wait_frame();
    chk("old_digit7_kept", cathode, 8'hF8);
    push(8'hFE, 8'h8E, 4);
    push(8'hFD, 8'h86, 4);
    push(8'hFB, 8'h86, 4);
    push(8'hF7, 8'h83, 4);
    push(8'hEF, 8'hA1, 4);
    push(8'hDF, 8'h88, 4);
    push(8'hBF, 8'h86, 4);
    push(8'h7F, 8'hA1, 0);
    start_mon();
    @(negedge clk);
    chk("ready_after_commit2", data_ready, 1'b1);
    drain();

    // digit enable mask and decimal point
    digit_en = 8'h0F;
    dp_i = 8'h01;
    wait_frame();
    push(8'hFE, 8'h0E, 4);
    push(8'hFD, 8'h86, 4);
    push(8'hFB, 8'h86, 4);
    push(8'hF7, 8'h83, 4);
    push(8'hFF, 8'hFF, 16);
    push(8'hFE, 8'h0E, 0);
    start_mon();
    drain();

    // leading zeros
    digit_en = 8'hFF;
    dp_i = 8'h00;
    send(32'h00000305);
    wait_frame();
    push(8'hFE, 8'h92, 4);
    push(8'hFD, 8'hC0, 4);
    push(8'hFB, 8'hB0, 4);
`ifdef LEADING_ZERO_BLANK_EN
    push(8'hFF, 8'hFF, 20);
    push(8'hFE, 8'h92, 0);
`else
    push(8'hF7, 8'hC0, 4);
    push(8'hEF, 8'hC0, 4);
    push(8'hDF, 8'hC0, 4);
    push(8'hBF, 8'hC0, 4);
    push(8'h7F, 8'hC0, 0);
`endif
    start_mon();
    drain();

    send(32'h00000000);
    wait_frame();
    push(8'hFE, 8'hC0, 4);
`ifdef LEADING_ZERO_BLANK_EN
    push(8'hFF, 8'hFF, 28);
    push(8'hFE, 8'hC0, 0);
`else
    push(8'hFD, 8'hC0, 4);
    push(8'hFB, 8'hC0, 4);
    push(8'hF7, 8'hC0, 4);
    push(8'hEF, 8'hC0, 4);
    push(8'hDF, 8'hC0, 4);
    push(8'hBF, 8'hC0, 4);
    push(8'h7F, 8'hC0, 0);
`endif
    start_mon();
    drain();

    // async reset mid-frame discards pending data
    send(32'h12345678);
    #3 rst = 1'b1;
    #1;
    chk("midrst_anode", anode, 8'hFF);
    chk("midrst_cathode", cathode, 8'hFF);
    chk("midrst_ready", data_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_anode", anode, 8'hFE);
    chk("post_rst_cathode", cathode, 8'hC0);
    chk("post_rst_ready", data_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
